// File: rtl/regfile_multiport.sv
// regfile_multiport: parametrised integer register file with NUM_RD registered
// read ports, one write-back port with sub-word extension, and a handshaked
// bulk-initialisation engine that streams one register per cycle.
// Optional build macro REGFILE_BYPASS_EN: when defined, reads are write-first
// (same-edge forwarding of the write value); otherwise reads are read-first.
module regfile_multiport #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD   = 2,
  parameter int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*XLEN-1:0]   rd_data,
  input  logic [2:0]               wr_mode,
  input  logic [AW-1:0]            wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     init_start,
  input  logic                     init_valid,
  output logic                     init_ready,
  input  logic [XLEN-1:0]          init_data,
  output logic                     busy,
  output logic                     init_done,
  output logic [NUM_REGS*XLEN-1:0] snapshot
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [AW-1:0] IDX_FIRST = AW'(1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(NUM_REGS - 1);

  logic [XLEN-1:0]        regs_q [NUM_REGS];
  logic [1:0]             state_q, state_d;
  logic [AW-1:0]          idx_q, idx_d;
  logic [NUM_RD*XLEN-1:0] rd_data_q;

  // Merged write port (core write-back or init engine)
  logic            we_w;
  logic [AW-1:0]   wa_w;
  logic [XLEN-1:0] wv_w;

  // Value written for a given write-back mode; unused modes give zero.
  function automatic logic [XLEN-1:0] extend(input logic [2:0] mode,
                                             input logic [XLEN-1:0] d);
    case (mode)
      3'd1:    return d;
      3'd2:    return {{(XLEN-16){d[15]}}, d[15:0]};
      3'd3:    return {{(XLEN-8){d[7]}}, d[7:0]};
      3'd4:    return {{(XLEN-16){1'b0}}, d[15:0]};
      3'd5:    return {{(XLEN-8){1'b0}}, d[7:0]};
      default: return '0;
    endcase
  endfunction

  // Only modes 1..5 write; X/Z modes fall into the default branch.
  function automatic logic mode_writes(input logic [2:0] mode);
    case (mode)
      3'd1, 3'd2, 3'd3, 3'd4, 3'd5: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  // Select the single writer for this cycle; core writes only while IDLE
  always_comb begin
    we_w = 1'b0;
    wa_w = wr_addr;
    wv_w = extend(wr_mode, wr_data);
    if (state_q == S_LOAD) begin
      wa_w = idx_q;
      wv_w = init_data;
      we_w = init_valid && (idx_q != '0);
    end else if (state_q == S_IDLE) begin
      we_w = mode_writes(wr_mode) && (wr_addr != '0);
    end
  end

  // Init engine next-state: IDLE -> LOAD -> DONE -> IDLE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (init_start) begin
          state_d = S_LOAD;
          idx_d   = IDX_FIRST;
        end
      end
      S_LOAD: begin
        if (init_valid) begin
          if (idx_q == IDX_LAST) state_d = S_DONE;
          else                   idx_d   = idx_q + AW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, register array and registered read ports
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= IDX_FIRST;
      rd_data_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (we_w) regs_q[wa_w] <= wv_w;
      for (int p = 0; p < NUM_RD; p++) begin
`ifdef REGFILE_BYPASS_EN
        if (we_w && (wa_w == rd_addr[p*AW +: AW]))
          rd_data_q[p*XLEN +: XLEN] <= wv_w;
        else
          rd_data_q[p*XLEN +: XLEN] <= regs_q[rd_addr[p*AW +: AW]];
`else
        rd_data_q[p*XLEN +: XLEN] <= regs_q[rd_addr[p*AW +: AW]];
`endif
      end
    end
  end

  assign rd_data    = rd_data_q;
  assign init_ready = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign init_done  = (state_q == S_DONE);

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_snap
    assign snapshot[i*XLEN +: XLEN] = regs_q[i];
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Self-checking bench for regfile_multiport (default parameters).
module tb_regfile_multiport;

  logic          clk = 1'b0;
  logic          reset;
  logic [9:0]    rd_addr;
  logic [63:0]   rd_data;
  logic [2:0]    wr_mode;
  logic [4:0]    wr_addr;
  logic [31:0]   wr_data;
  logic          init_start;
  logic          init_valid;
  logic          init_ready;
  logic [31:0]   init_data;
  logic          busy;
  logic          init_done;
  logic [1023:0] snapshot;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m [32];

  regfile_multiport dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_mode(wr_mode), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_start(init_start), .init_valid(init_valid), .init_ready(init_ready),
    .init_data(init_data), .busy(busy), .init_done(init_done), .snapshot(snapshot)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference write value, by arithmetic on the architectural rules.
  function automatic logic [31:0] ref_val(input logic [2:0] mode, input logic [31:0] d);
    case (mode)
      3'd1: return d;
      3'd2: return ((d & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd3: return ((d & 32'hFF) ^ 32'h80) - 32'h80;
      3'd4: return d & 32'hFFFF;
      3'd5: return d & 32'hFF;
      default: return 32'h0;
    endcase
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_rd_data got=%h want=0", rd_data); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
    n_checks++; if (init_ready !== 1'b0) begin n_fail++; $display("FAIL reset_init_ready got=%b want=0", init_ready); end
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL reset_init_done got=%b want=0", init_done); end
    n_checks++; if (snapshot !== '0) begin n_fail++; $display("FAIL reset_snapshot nonzero"); end
    reset = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(a), 5'(a)};
      step();
      n_checks++;
      if (rd_data !== 64'h0) begin n_fail++; $display("FAIL reset_read addr=%0d got=%h want=0", a, rd_data); end
    end
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
  endtask

  task automatic test_word_write();
    wr_mode = 3'd1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    step();
    wr_mode = 3'd0;
    step();
    m[5] = 32'hDEADBEEF;
    n_checks++; if (rd_data[31:0] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL word_write got=%h want=deadbeef", rd_data[31:0]); end
    wr_mode = 3'd1; wr_addr = 5'd0; wr_data = 32'h1234; rd_addr = {5'd0, 5'd0};
    step();
    wr_mode = 3'd0;
    step();
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL write_r0 got=%h want=0", rd_data); end
    n_checks++; if (snapshot[31:0] !== 32'h0) begin n_fail++; $display("FAIL snap_r0 got=%h want=0", snapshot[31:0]); end
  endtask

  task automatic test_subword();
    logic [31:0] exp_v [8];
    exp_v[2] = 32'hFFFF8081; exp_v[3] = 32'hFFFFFF81;
    exp_v[4] = 32'h00008081; exp_v[5] = 32'h00000081; exp_v[6] = 32'h00000081;
    for (int md = 2; md <= 6; md++) begin
      wr_mode = 3'(md); wr_addr = 5'd7; wr_data = 32'h00008081; rd_addr = {5'd7, 5'd7};
      step();
      wr_mode = 3'd0;
      step();
      n_checks++;
      if (rd_data[31:0] !== exp_v[md]) begin n_fail++; $display("FAIL subword mode=%0d got=%h want=%h", md, rd_data[31:0], exp_v[md]); end
      n_checks++;
      if (rd_data[63:32] !== exp_v[md]) begin n_fail++; $display("FAIL subword_p1 mode=%0d got=%h want=%h", md, rd_data[63:32], exp_v[md]); end
    end
    m[7] = 32'h00000081;
  endtask

  task automatic test_init_load();
    int accepts = 0, cyc = 0, pulses = 0, nxt = 1;
    logic rdy, vld, mid = 1'b0;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL load_busy got=%b want=1", busy); end
    while (accepts < 31 && cyc < 300) begin
      init_valid = (cyc % 2 == 0);
      init_data  = 32'h100 + nxt;
      if (accepts == 6 && !mid) begin
        wr_mode = 3'd1; wr_addr = 5'd3; wr_data = 32'hBAD0BAD0; mid = 1'b1;
      end else wr_mode = 3'd0;
      rdy = init_ready; vld = init_valid;
      step();
      cyc++;
      if (init_done === 1'b1) pulses++;
      if (rdy && vld) begin m[nxt] = 32'h100 + nxt; nxt++; accepts++; end
    end
    init_valid = 1'b0; wr_mode = 3'd0;
    n_checks++; if (accepts != 31) begin n_fail++; $display("FAIL load_timeout accepts=%0d want=31", accepts); end
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL load_done got=%b want=1", init_done); end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL load_pulses got=%0d want=1", pulses); end
    step();
    n_checks++; if (init_done !== 1'b0) begin n_fail++; $display("FAIL done_len got=%b want=0", init_done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL load_busy_fall got=%b want=0", busy); end
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (snapshot[i*32 +: 32] !== m[i]) begin n_fail++; $display("FAIL load_snap reg=%0d got=%h want=%h", i, snapshot[i*32 +: 32], m[i]); end
    end
  endtask

  task automatic test_reset_mid_load();
    int accepts = 0, cyc = 0, nxt = 1;
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    init_valid = 1'b1;
    while (accepts < 10 && cyc < 100) begin
      init_data = 32'h200 + nxt;
      step();
      cyc++; accepts++; nxt++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0; init_valid = 1'b0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b want=0", busy); end
    n_checks++; if (init_ready !== 1'b0) begin n_fail++; $display("FAIL abort_ready got=%b want=0", init_ready); end
    n_checks++; if (snapshot !== '0) begin n_fail++; $display("FAIL abort_snapshot nonzero"); end
    n_checks++; if (rd_data !== 64'h0) begin n_fail++; $display("FAIL abort_rd_data got=%h want=0", rd_data); end
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    accepts = 0; cyc = 0; nxt = 1;
    init_valid = 1'b1;
    while (accepts < 31 && cyc < 100) begin
      init_data = 32'h300 + nxt;
      if (init_ready) begin m[nxt] = 32'h300 + nxt; nxt++; accepts++; end
      step();
      cyc++;
    end
    init_valid = 1'b0;
    n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL restart_done got=%b want=1", init_done); end
    step();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (snapshot[i*32 +: 32] !== m[i]) begin n_fail++; $display("FAIL restart_snap reg=%0d got=%h want=%h", i, snapshot[i*32 +: 32], m[i]); end
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] want;
    wr_mode = 3'd1; wr_addr = 5'd9; wr_data = 32'h11111111; rd_addr = {5'd0, 5'd0};
    step();
    m[9] = 32'h11111111;
    wr_mode = 3'd1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5; rd_addr = {5'd0, 5'd9};
    step();
    wr_mode = 3'd0;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5A5A5;
`else
    want = m[9];
`endif
    m[9] = 32'hA5A5A5A5;
    n_checks++; if (rd_data[31:0] !== want) begin n_fail++; $display("FAIL same_cycle got=%h want=%h", rd_data[31:0], want); end
    step();
    n_checks++; if (rd_data[31:0] !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL same_cycle_next got=%h want=a5a5a5a5", rd_data[31:0]); end
  endtask

  task automatic test_random();
    logic [2:0]  md;
    logic [4:0]  wa, ra0, ra1;
    logic [31:0] wd, e0, e1, v;
    logic        w;
    for (int n = 0; n < 400; n++) begin
      md = 3'($urandom_range(0, 7));
      wa = 5'($urandom_range(0, 31));
      wd = $urandom;
      ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      wr_mode = md; wr_addr = wa; wr_data = wd; rd_addr = {ra1, ra0};
      w = (md >= 3'd1 && md <= 3'd5 && wa != 5'd0);
      v = ref_val(md, wd);
      e0 = m[ra0]; e1 = m[ra1];
`ifdef REGFILE_BYPASS_EN
      if (w && ra0 == wa) e0 = v;
      if (w && ra1 == wa) e1 = v;
`endif
      if (w) m[wa] = v;
      step();
      n_checks++;
      if (rd_data[31:0] !== e0) begin n_fail++; $display("FAIL rand_p0 n=%0d addr=%0d got=%h want=%h", n, ra0, rd_data[31:0], e0); end
      n_checks++;
      if (rd_data[63:32] !== e1) begin n_fail++; $display("FAIL rand_p1 n=%0d addr=%0d got=%h want=%h", n, ra1, rd_data[63:32], e1); end
    end
    wr_mode = 3'd0;
    step();
    for (int i = 0; i < 32; i++) begin
      n_checks++;
      if (snapshot[i*32 +: 32] !== m[i]) begin n_fail++; $display("FAIL rand_snap reg=%0d got=%h want=%h", i, snapshot[i*32 +: 32], m[i]); end
    end
  endtask

  initial begin
    reset = 1'b1; rd_addr = '0; wr_mode = 3'd0; wr_addr = '0; wr_data = '0;
    init_start = 1'b0; init_valid = 1'b0; init_data = '0;
    test_reset();
    test_word_write();
    test_subword();
    test_init_load();
    test_reset_mid_load();
    test_same_cycle();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
